// File: rtl/cpu_ctrl_pkg.sv
// Shared control constants for the PC sequencing controller.
// Holds the FSM state encoding (visible on state_dbg), instruction opcode/funct
// values, PC source select codes and exception cause codes.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH      = 4'd0,
    FETCH_WAIT = 4'd1,
    DECODE     = 4'd2,
    BRANCH     = 4'd3,
    JUMP       = 4'd4,
    JR         = 4'd5,
    RTE        = 4'd6,
    EXEC       = 4'd7,
    EXEC_WAIT  = 4'd8,
    EXC_SAVE   = 4'd9,
    EXC_LOAD   = 4'd10,
    EXC_WAIT   = 4'd11,
    EXC_JUMP   = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_OPCODE   = 2'd0,
    CAUSE_OVERFLOW = 2'd1,
    CAUSE_DIV_ZERO = 2'd2
  } cause_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_RTE   = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] PC_A         = 3'b000;
  localparam logic [2:0] PC_ULAOUT    = 3'b001;
  localparam logic [2:0] PC_SLAC      = 3'b010;
  localparam logic [2:0] PC_EPCOUT    = 3'b011;
  localparam logic [2:0] PC_MDROUT    = 3'b100;
  localparam logic [2:0] PC_ULARESULT = 3'b101;

  // Opcodes handed to the datapath executor (everything but branch/jump/RTE).
  function automatic logic is_exec_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_ANDI) ||
           (op == OP_ORI)   || (op == OP_LUI)  || (op == OP_LW)   ||
           (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Memory wait counter: loadable down-counter that saturates at zero.
// Ports: clk, reset (async active-low), load/load_val (load has priority),
//        dec (decrement when non-zero), zero (count is zero).
module mem_wait_cnt #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencing controller: multi-cycle fetch/decode/branch/exception FSM.
// Ports: clk, reset (async active-low); opcode/funct from IR; zero, overflow,
//        div_zero, exec_done status from datapath. Outputs PCmux (PC source),
//        pc_write, ir_write, mem_rd, epc_write, exec_start strobes, vec_sel
//        (memory address source) and state_dbg (current state encoding).
module pc_seq_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       div_zero,
  input  logic       exec_done,
  output logic [2:0] PCmux,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_rd,
  output logic       epc_write,
  output logic       exec_start,
  output logic [1:0] vec_sel,
  output logic [3:0] state_dbg
);

  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

  state_t state, state_next;
  cause_t cause, cause_next;
  logic   cnt_load, cnt_dec, cnt_zero;

  mem_wait_cnt #(.WIDTH(3)) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      cause <= CAUSE_OPCODE;
    end else begin
      state <= state_next;
      cause <= cause_next;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    PCmux      = PC_ULARESULT;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_rd     = 1'b0;
    epc_write  = 1'b0;
    exec_start = 1'b0;
    vec_sel    = 2'b00;

    case (state)
      FETCH: begin
        mem_rd     = 1'b1;
        cnt_load   = 1'b1;
        state_next = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (cnt_zero) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DECODE: begin
        if (opcode == OP_BEQ || opcode == OP_BNE) begin
          state_next = BRANCH;
        end else if (opcode == OP_J) begin
          state_next = JUMP;
        end else if (opcode == OP_RTE) begin
          state_next = RTE;
        end else if (opcode == OP_RTYPE && funct == FN_JR) begin
          state_next = JR;
        end else if (is_exec_op(opcode)) begin
          state_next = EXEC;
        end else begin
          cause_next = CAUSE_OPCODE;
          state_next = EXC_SAVE;
        end
      end
      BRANCH: begin
        PCmux      = PC_ULAOUT;
        pc_write   = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);
        state_next = FETCH;
      end
      JUMP: begin
        PCmux      = PC_SLAC;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      JR: begin
        PCmux      = PC_A;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      RTE: begin
        PCmux      = PC_EPCOUT;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      EXEC: begin
        exec_start = 1'b1;
        state_next = EXEC_WAIT;
      end
      EXEC_WAIT: begin
        if (exec_done) begin
          if (div_zero) begin
            cause_next = CAUSE_DIV_ZERO;
            state_next = EXC_SAVE;
          end else if (overflow) begin
            cause_next = CAUSE_OVERFLOW;
            state_next = EXC_SAVE;
          end else begin
            state_next = FETCH;
          end
        end
      end
      EXC_SAVE: begin
        epc_write  = 1'b1;
        state_next = EXC_LOAD;
      end
      EXC_LOAD: begin
        mem_rd     = 1'b1;
        vec_sel    = 2'(cause) + 2'd1;
        cnt_load   = 1'b1;
        state_next = EXC_WAIT;
      end
      EXC_WAIT: begin
        if (cnt_zero) begin
          state_next = EXC_JUMP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      EXC_JUMP: begin
        PCmux      = PC_MDROUT;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      default: begin
        state_next = FETCH;
      end
    endcase

    // State is forced to FETCH during reset, but FETCH's mem_rd must stay
    // quiet until reset is released.
    if (!reset) begin
      PCmux      = PC_ULARESULT;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_rd     = 1'b0;
      epc_write  = 1'b0;
      exec_start = 1'b0;
      vec_sel    = 2'b00;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl. A reference model expands each
// instruction into its expected per-cycle output trace; the bench then drives
// the instruction and compares every cycle against that trace.
module tb_pc_seq_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int unsigned MW = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       overflow = 1'b0;
  logic       div_zero = 1'b0;
  logic       exec_done = 1'b0;
  logic [2:0] PCmux;
  logic       pc_write, ir_write, mem_rd, epc_write, exec_start;
  logic [1:0] vec_sel;
  logic [3:0] state_dbg;

  pc_seq_ctrl #(.MEM_WAIT(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .overflow   (overflow),
    .div_zero   (div_zero),
    .exec_done  (exec_done),
    .PCmux      (PCmux),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_rd     (mem_rd),
    .epc_write  (epc_write),
    .exec_start (exec_start),
    .vec_sel    (vec_sel),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       pw;
    logic       iw;
    logic       mr;
    logic       ew;
    logic       es;
    logic [2:0] pcm;
    logic [1:0] vs;
  } obs_t;

  obs_t exp_q[$];
  bit   done_q[$];

  function automatic obs_t mk(input logic [3:0] st, input logic pw, input logic iw,
                              input logic mr, input logic ew, input logic es,
                              input logic [2:0] pcm, input logic [1:0] vs);
    obs_t o;
    o.st = st; o.pw = pw; o.iw = iw; o.mr = mr; o.ew = ew; o.es = es;
    o.pcm = pcm; o.vs = vs;
    return o;
  endfunction

  function automatic obs_t idle(input logic [3:0] st);
    return mk(st, 0, 0, 0, 0, 0, 3'b101, 2'b00);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = {state_dbg, pc_write, ir_write, mem_rd, epc_write, exec_start, PCmux, vec_sel};
    return o;
  endfunction

  // Reference model: expected trace of one instruction, FETCH through the
  // cycle before the next FETCH. done_q marks where exec_done is driven.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int dly, input logic ov, input logic dz, input bit spur);
    int cause;
    bit legal_exec;
    cause = -1;
    exp_q.delete();
    done_q.delete();
    legal_exec = (op == 6'h00 || op == 6'h08 || op == 6'h0C || op == 6'h0D ||
                  op == 6'h23 || op == 6'h2B || op == 6'h0F);
    exp_q.push_back(mk(FETCH, 0, 0, 1, 0, 0, 3'b101, 2'b00)); done_q.push_back(spur);
    for (int i = 0; i < int'(MW) - 1; i++) begin
      exp_q.push_back(idle(FETCH_WAIT)); done_q.push_back(spur);
    end
    exp_q.push_back(mk(FETCH_WAIT, 1, 1, 0, 0, 0, 3'b101, 2'b00)); done_q.push_back(spur);
    exp_q.push_back(idle(DECODE)); done_q.push_back(spur);
    if (op == 6'h04 || op == 6'h05) begin
      exp_q.push_back(mk(BRANCH, (op == 6'h04) ? z : !z, 0, 0, 0, 0, 3'b001, 2'b00));
      done_q.push_back(spur);
    end else if (op == 6'h02) begin
      exp_q.push_back(mk(JUMP, 1, 0, 0, 0, 0, 3'b010, 2'b00)); done_q.push_back(spur);
    end else if (op == 6'h10) begin
      exp_q.push_back(mk(RTE, 1, 0, 0, 0, 0, 3'b011, 2'b00)); done_q.push_back(spur);
    end else if (op == 6'h00 && fn == 6'h08) begin
      exp_q.push_back(mk(JR, 1, 0, 0, 0, 0, 3'b000, 2'b00)); done_q.push_back(spur);
    end else if (legal_exec) begin
      exp_q.push_back(mk(EXEC, 0, 0, 0, 0, 1, 3'b101, 2'b00)); done_q.push_back(spur);
      for (int i = 1; i <= dly; i++) begin
        exp_q.push_back(idle(EXEC_WAIT)); done_q.push_back(i == dly);
      end
      if (dz) cause = 2;
      else if (ov) cause = 1;
    end else begin
      cause = 0;
    end
    if (cause >= 0) begin
      exp_q.push_back(mk(EXC_SAVE, 0, 0, 0, 1, 0, 3'b101, 2'b00)); done_q.push_back(spur);
      exp_q.push_back(mk(EXC_LOAD, 0, 0, 1, 0, 0, 3'b101, 2'(cause + 1)));
      done_q.push_back(spur);
      for (int i = 0; i < int'(MW); i++) begin
        exp_q.push_back(idle(EXC_WAIT)); done_q.push_back(spur);
      end
      exp_q.push_back(mk(EXC_JUMP, 1, 0, 0, 0, 0, 3'b100, 2'b00)); done_q.push_back(spur);
    end
  endtask

  // Called just after a rising edge with the DUT in FETCH; leaves it the same way.
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int dly, input logic ov, input logic dz,
                     input bit spur);
    obs_t o;
    build(op, fn, z, dly, ov, dz, spur);
    opcode = op; funct = fn; zero = z; overflow = ov; div_zero = dz;
    for (int i = 0; i < exp_q.size(); i++) begin
      exec_done = done_q[i];
      @(negedge clk);
      o = sample();
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL %s op=%h cycle %0d: got 0x%h expected 0x%h",
                 tag, op, i, o, exp_q[i]);
      end
      @(posedge clk);
      #1;
    end
    exec_done = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b0;
    exec_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = sample();
      checks++;
      if (o !== idle(FETCH)) begin
        errors++;
        $display("FAIL reset_state: got 0x%h expected 0x%h", o, idle(FETCH));
      end
    end
    exec_done = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_fetch_and_jumps();
    run("jump", 6'h02, 6'h00, 0, 1, 0, 0, 0);
    run("jr",   6'h00, 6'h08, 0, 1, 0, 0, 0);
    run("rte",  6'h10, 6'h15, 1, 1, 0, 0, 0);
  endtask

  task automatic test_branch();
    run("beq_taken",     6'h04, 6'h00, 1, 1, 0, 0, 0);
    run("beq_not_taken", 6'h04, 6'h00, 0, 1, 0, 0, 0);
    run("bne_taken",     6'h05, 6'h00, 0, 1, 0, 0, 0);
    run("bne_not_taken", 6'h05, 6'h00, 1, 1, 0, 0, 0);
  endtask

  task automatic test_illegal();
    run("illegal_3f", 6'h3F, 6'h00, 0, 1, 0, 0, 1);
  endtask

  task automatic test_exec();
    run("exec_both_flags", 6'h00, 6'h20, 0, 5, 1, 1, 1);
    run("exec_overflow",   6'h08, 6'h00, 0, 3, 1, 0, 0);
    run("exec_divzero",    6'h23, 6'h00, 0, 1, 0, 1, 0);
    run("exec_clean",      6'h2B, 6'h00, 0, 2, 0, 0, 1);
  endtask

  task automatic test_reset_in_exc_wait();
    bit found;
    found = 0;
    opcode = 6'h3F; funct = '0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (state_dbg === EXC_WAIT) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL exc_wait_reached: got state %0d required %0d", state_dbg, EXC_WAIT);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (state_dbg !== FETCH || pc_write !== 1'b0 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got state=%0d pc_write=%b mem_rd=%b required state=%0d 0 0",
               state_dbg, pc_write, mem_rd, FETCH);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    run("post_reset", 6'h02, 6'h00, 0, 1, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [5:0] ops [12];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h10,
            6'h23, 6'h2B, 6'h00};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 11)];
      fn = ($urandom_range(0, 2) == 0) ? 6'h08 : 6'($urandom);
      run("random", op, fn, 1'($urandom), int'($urandom_range(1, 6)),
          1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fetch_and_jumps();
    test_branch();
    test_illegal();
    test_exec();
    test_reset_in_exc_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_WAIT, default 2, giving memory read latency in cycles (legal range 1..7).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port opcode, input, 6 bits: the IR[31:26] field, valid from DECODE onward.
REQ-005 The block SHALL have port funct, input, 6 bits: the IR[5:0] field.
REQ-006 The block SHALL have port zero, input, 1 bit: the ALU zero flag during BRANCH.
REQ-007 The block SHALL have port overflow, input, 1 bit: the arithmetic overflow flag, sampled only in EXEC_WAIT.
REQ-008 The block SHALL have port div_zero, input, 1 bit: the divide-by-zero flag, sampled only in EXEC_WAIT.
REQ-009 The block SHALL have port exec_done, input, 1 bit: the datapath executor completion pulse.
REQ-010 The block SHALL have port PCmux, output, 3 bits: the PC source select (000 A, 001 ULAout, 010 SLAC, 011 EPCout, 100 MDRout, 101 ULAresult).
REQ-011 The block SHALL have outputs pc_write, ir_write, mem_rd, epc_write and exec_start, each 1 bit.
REQ-012 The block SHALL have output vec_sel, 2 bits: memory address source (00 PC, 01 vector 253, 10 vector 254, 11 vector 255).
REQ-013 The block SHALL have output state_dbg, 4 bits: the current FSM state encoding.

Function
REQ-014 The FSM SHALL use the states FETCH, FETCH_WAIT, DECODE, BRANCH, JUMP, JR, RTE, EXEC, EXEC_WAIT, EXC_SAVE, EXC_LOAD, EXC_WAIT and EXC_JUMP.
REQ-015 FETCH SHALL assert mem_rd with vec_sel=00 and load the wait counter with MEM_WAIT-1, then go to FETCH_WAIT.
REQ-016 FETCH_WAIT SHALL decrement the counter; at 0 it SHALL assert ir_write, pc_write and PCmux=101 for one cycle, then go to DECODE.
REQ-017 DECODE SHALL dispatch on opcode: 0x04/0x05 to BRANCH; 0x02 to JUMP; 0x10 to RTE; 0x00 with funct 0x08 to JR; other legal opcodes (0x00, 0x08, 0x0C, 0x0D, 0x23, 0x2B, 0x0F) to EXEC; anything else to EXC_SAVE with cause 0.
REQ-018 BRANCH SHALL set PCmux=001 and assert pc_write iff (opcode=0x04 and zero=1) or (opcode=0x05 and zero=0), then return to FETCH.
REQ-019 JUMP SHALL drive PCmux=010 with pc_write; JR SHALL drive PCmux=000 with pc_write; RTE SHALL drive PCmux=011 with pc_write; each is one cycle and returns to FETCH.
REQ-020 EXEC SHALL pulse exec_start for exactly one cycle, then go to EXEC_WAIT.
REQ-021 EXEC_WAIT SHALL hold all strobes low until exec_done=1; then div_zero goes to EXC_SAVE with cause 2, else overflow goes to EXC_SAVE with cause 1, else FETCH.
REQ-022 Simultaneous overflow and div_zero SHALL select cause 2; exec_done while not in EXEC_WAIT SHALL be ignored.
REQ-023 EXC_SAVE SHALL assert epc_write for one cycle.
REQ-024 EXC_LOAD SHALL assert mem_rd with vec_sel = cause+1 and load the counter; EXC_WAIT SHALL count exactly as in FETCH_WAIT.
REQ-025 EXC_JUMP SHALL drive PCmux=100 with pc_write, then return to FETCH.
REQ-026 In every state not named above as driving them, pc_write, ir_write, mem_rd, epc_write and exec_start SHALL be 0, and PCmux SHALL be 101.
REQ-027 All outputs SHALL be decoded from registered state only (Moore), except pc_write in BRANCH, which also depends on zero.

Reset
REQ-028 While reset=0, the state SHALL be FETCH, the counter and cause SHALL be 0, and all strobes SHALL be 0 with PCmux=101 and vec_sel=00.
REQ-029 Reset asserted mid-operation, including during EXC_WAIT, SHALL abort immediately; the first post-reset cycle SHALL be FETCH with mem_rd=1.

Structure
REQ-030 State encodings, opcode/funct constants, PCmux codes and cause codes SHALL reside in the shared package cpu_ctrl_pkg.
REQ-031 The wait counter SHALL be a sub-module mem_wait_cnt (load, decrement, zero flag).

Verification
REQ-032 After reset with MEM_WAIT=2, the bench SHALL check mem_rd=1 in cycle 1 and ir_write=pc_write=1 with PCmux=101 in cycle 3.
REQ-033 With opcode 0x04 and zero=1, the bench SHALL check BRANCH gives pc_write=1 with PCmux=001; with zero=0 it SHALL check pc_write=0 and that the next state is FETCH.
REQ-034 With opcode 0x00 and funct 0x08, the bench SHALL check PCmux=000 with pc_write; with opcode 0x02 it SHALL check PCmux=010; with opcode 0x10 it SHALL check PCmux=011.
REQ-035 With opcode 0x3F, the bench SHALL check the sequence epc_write, then mem_rd with vec_sel=01, then PCmux=100 with pc_write.
REQ-036 With opcode 0x00, exec_done after 5 cycles and overflow=div_zero=1, the bench SHALL check a single exec_start pulse and vec_sel=11.
REQ-037 Reset pulsed during EXC_WAIT SHALL yield state_dbg=FETCH and no pc_write.
